// File: rtl/dff_arb_pkg.sv
// Shared types and constants for the dff_bank_arbiter block.
// Contents:
//   state_e   - EMPTY / FULL occupancy of the shared capture register
//   idx_w()   - owner-index width for a given requester count
//   N_REQ_DEF - default number of requesters
//   WIDTH_DEF - default data word width
package dff_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Purely combinational round-robin picker.
// Ports:
//   req      in  N_REQ  pending requests, bit i = requester i
//   ptr      in  IDX_W  highest-priority index for this pick
//   pick     out N_REQ  one-hot selection (zero when nothing is pending)
//   pick_idx out IDX_W  binary index of the selection
//   any      out 1      at least one request is pending
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  // Doubling the request vector turns the circular scan
  // ptr..N_REQ-1, 0..ptr-1 into a plain linear scan starting at ptr.
  logic [2*N_REQ-1:0] w_dbl;
  assign w_dbl = {req, req};

  // NOTE: every output gets a default before the loop so no path leaves
  // it unassigned; that is what keeps this block free of latches.
  always_comb begin
    any      = 1'b0;
    pick_idx = '0;
    pick     = '0;
    for (int j = 0; j < 2 * N_REQ; j++) begin
      if (!any && (j >= int'(ptr)) && w_dbl[j]) begin
        any      = 1'b1;
        pick_idx = IDX_W'(j % N_REQ);
      end
    end
    if (any) pick[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// One WIDTH-bit capture register shared by N_REQ requesters. A round-robin
// arbiter picks one pending requester per capture and loads its word; the
// word is then offered downstream with a valid/ready handshake.
// Ports:
//   clk      in  1            clock, rising edge
//   rst_n    in  1            asynchronous active-low reset
//   clr      in  1            synchronous clear, active high
//   req      in  N_REQ        per-requester request
//   req_data in  N_REQ*WIDTH  slice [i*WIDTH +: WIDTH] belongs to requester i
//   gnt      out N_REQ        one-hot capture strobe (combinational)
//   q        out WIDTH        captured word
//   q_valid  out 1            q holds an unconsumed word
//   q_owner  out IDX_W        requester whose word is in q
//   q_ready  in  1            consumer accepts q this cycle
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [idx_w(N_REQ)-1:0]  q_owner,
  input  logic                     q_ready
);

  localparam int IDX_W = idx_w(N_REQ);

  state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [WIDTH-1:0]   r_q;
  logic [IDX_W-1:0]   r_owner;

  logic [N_REQ-1:0]   w_pick;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_any;
  logic               w_cap;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (req),
    .ptr      (r_ptr),
    .pick     (w_pick),
    .pick_idx (w_pick_idx),
    .any      (w_any)
  );

  // rst_n is folded in so no strobe escapes while reset is held.
  assign w_cap = rst_n && w_any && !clr && ((r_state == EMPTY) || q_ready);
  assign gnt   = w_pick & {N_REQ{w_cap}};

  always_comb begin
    w_state_nxt = r_state;
    if (clr)                          w_state_nxt = EMPTY;
    else if (w_cap)                   w_state_nxt = FULL;
    else if (r_state == FULL && q_ready) w_state_nxt = EMPTY;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_ptr   <= '0;
      r_q     <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (clr) begin
        r_ptr   <= '0;
        r_q     <= '0;
        r_owner <= '0;
      end else if (w_cap) begin
        r_q     <= req_data[w_pick_idx*WIDTH +: WIDTH];
        r_owner <= w_pick_idx;
        r_ptr   <= (w_pick_idx == IDX_W'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
      end
    end
  end

  assign q       = r_q;
  assign q_valid = (r_state == FULL);
  assign q_owner = r_owner;

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Shares one WIDTH-bit capture register (a bank of D flip-flops) between N_REQ requesters.
- A round-robin arbiter selects one pending requester per capture and loads its data word into the register.
- The stored word is then presented downstream with a valid/ready handshake.
- Sits between several producer blocks and a single consumer that accepts one word at a time.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, data word width in bits.
- IDX_W, $clog2(N_REQ), width of the owner index (derived, not overridden).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear, active high.
- req  input  N_REQ  per-requester request, bit i = requester i.
- req_data  input  N_REQ*WIDTH  packed data, slice [i*WIDTH +: WIDTH] belongs to requester i.
- gnt  output  N_REQ  one-hot capture strobe (combinational).
- q  output  WIDTH  captured data word.
- q_valid  output  1  q holds an unconsumed word.
- q_owner  output  IDX_W  index of the requester whose data is in q.
- q_ready  input  1  consumer accepts q this cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - q=0, q_valid=0, q_owner=0.
  - Round-robin pointer ptr=0, state EMPTY.
  - gnt=0 while rst_n is low.
- States:
  - EMPTY: q_valid=0.
  - FULL: q_valid=1.
- Capture condition: cap = |req && !clr && (state==EMPTY || q_ready).
- Selection:
  - Take the first set req bit scanning ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
  - If cap, gnt is one-hot on the selected index; otherwise gnt=0.
- On a cap edge:
  - q <= selected slice, q_owner <= selected index, ptr <= (index+1) mod N_REQ.
  - State becomes FULL.
- Requester protocol:
  - req and its data are held stable until the requester sees gnt[i]=1.
  - The edge on which gnt[i]=1 is the edge that captures that data.
  - The requester may drop req, or present the next word, in the following cycle.
- Latency: data is visible on q one cycle after the capture edge, i.e. in the cycle after gnt.
- FULL with q_ready=1 and no req: the word is consumed and the state goes to EMPTY. q and q_owner keep their values; only q_valid falls.
- FULL with q_ready=1 and any req: back-to-back capture. The state stays FULL, q is replaced, and there is no bubble.
- FULL with q_ready=0: q, q_owner, q_valid and ptr are all held; gnt=0 regardless of req.
- EMPTY with q_ready=1 has no effect.
- ptr changes only on a capture.
  - A sole requester is granted on every capture opportunity.
  - The requester at ptr has priority over all others.
- Wrap-around: a grant to index N_REQ-1 sets ptr=0.
- clr=1 (synchronous, highest priority after reset):
  - gnt=0 combinationally.
  - Next edge: q=0, q_valid=0, q_owner=0, ptr=0, state EMPTY. Any in-flight word is discarded.
- rst_n assertion mid-transfer clears all state immediately; the in-flight word is lost.
- q_valid must never rise without a gnt pulse on the preceding edge.
- gnt is never asserted for an index whose req bit is 0.

Decomposition:
- Package dff_arb_pkg holds:
  - the state_e enum {EMPTY, FULL};
  - a localparam function for IDX_W;
  - the default N_REQ and WIDTH constants.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req[N_REQ], ptr[IDX_W].
  - Outputs: one-hot pick[N_REQ], pick_idx[IDX_W], any.
  - Implemented as a double-width masked priority encode.
- The top level holds the FSM, ptr, the data/owner registers and the gnt gating (gnt = pick & {N_REQ{cap}}).

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles with req=4'b1111, then release with req=0 → q=0, q_valid=0, q_owner=0, gnt=0 throughout.
- Single capture and handshake: req=4'b0100 with data2=8'hA5, q_ready=0 → gnt=4'b0100 for exactly one cycle; next cycle q=8'hA5, q_owner=2, q_valid=1. Valid is held for 5 cycles; q_ready=1 for one cycle then gives q_valid=0.
- Round-robin fairness: req=4'b1111 held, q_ready=1 constantly, data i=8'h10+i → grants 0,1,2,3,0 on consecutive cycles; q sequence 8'h10, 11, 12, 13, 10; no bubbles; q_valid stays 1.
- Back-pressure: FULL with q_ready=0 and req=4'b0011 → gnt=0 and q unchanged for 10 cycles. Raising q_ready gives gnt on the next-in-order index relative to ptr.
- Wrap and pointer: grant to index 3, then req=4'b1001 → next grant is index 0 (ptr=0), and the following grant is index 3.
- clr and async reset mid-operation:
  - FULL with q=8'h5A and req=4'b0010, pulse clr → gnt=0 that cycle; next cycle q=0, q_valid=0, ptr=0.
  - Repeat with rst_n pulsed low mid-cycle → outputs clear before the next clk edge.
